// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, fetch FSM states, reset vector.
package pipeline_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC flop: synchronous reset to a fixed vector, load enable.
module pc_reg #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC generator with execute-stage redirect and stale-response drop.
module pc_redirect
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic            InstrValidF,
  output logic            FetchWaitF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            FlushD,
  output logic            FlushE
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            unused_lsbs;

  assign target      = {PCTargetE[XLEN-1:2], 2'b00};
  assign unused_lsbs = ^PCTargetE[1:0];
  assign PCPlus4F    = PCF + XLEN'(4);

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_next    = PCF;
    unique case (state)
      FETCH: begin
        if (PCSrcE) begin
          pc_load = 1'b1;
          pc_next = target;
          // Response still owed for the old PC: must be swallowed.
          if (!imem_ready) state_next = DROP;
        end else if (imem_ready && !StallF) begin
          pc_load = 1'b1;
          pc_next = PCPlus4F;
        end
      end
      DROP: begin
        if (PCSrcE) begin
          pc_load = 1'b1;
          pc_next = target;
        end
        if (imem_ready) state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_load),
    .d     (pc_next),
    .q     (PCF)
  );

  assign imem_req    = !reset && (state == FETCH);
  assign imem_addr   = PCF;
  assign InstrValidF = imem_req && imem_ready && !PCSrcE;
  assign FetchWaitF  = !InstrValidF;
  assign FlushD      = !reset && PCSrcE;
  assign FlushE      = !reset && PCSrcE;

endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect: directed scenarios plus random run.
module tb_pc_redirect;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        InstrValidF;
  logic        FetchWaitF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FlushD;
  logic        FlushE;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .StallF      (StallF),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .InstrValidF (InstrValidF),
    .FetchWaitF  (FetchWaitF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .FlushD      (FlushD),
    .FlushE      (FlushE)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit later, well away from either clock edge.
  task automatic drive(input logic r, input logic ps, input logic [31:0] t,
                       input logic st, input logic rdy);
    reset = r; PCSrcE = ps; PCTargetE = t; StallF = st; imem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h0000_0ABC, 1'b0, 1'b1);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL reset_req got=%b exp=0", imem_req);
    end
    total++;
    if (InstrValidF !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", InstrValidF);
    end
    total++;
    if (FlushD !== 1'b0 || FlushE !== 1'b0) begin
      bad++; $display("FAIL reset_flush got=%b%b exp=00", FlushD, FlushE);
    end
    tick();
    total++;
    if (PCF !== 32'h0) begin
      bad++; $display("FAIL reset_pc got=%h exp=0", PCF);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (PCF !== 32'(4 * i) || imem_addr !== 32'(4 * i)) begin
        bad++; $display("FAIL seq_pc got=%h/%h exp=%h", PCF, imem_addr, 4 * i);
      end
      total++;
      if (InstrValidF !== 1'b1 || FetchWaitF !== 1'b0 || imem_req !== 1'b1) begin
        bad++; $display("FAIL seq_valid got=%b%b%b exp=110",
                        InstrValidF, imem_req, FetchWaitF);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
    total++;
    if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
      bad++; $display("FAIL redir_flush got=%b%b exp=11", FlushD, FlushE);
    end
    total++;
    if (InstrValidF !== 1'b0 || FetchWaitF !== 1'b1) begin
      bad++; $display("FAIL redir_valid got=%b/%b exp=0/1", InstrValidF, FetchWaitF);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (PCF !== 32'h0000_0100 || imem_req !== 1'b1) begin
      bad++; $display("FAIL redir_pc got=%h req=%b exp=100 req=1", PCF, imem_req);
    end
  endtask

  task automatic test_drop();
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, i == 2);
      total++;
      if (imem_req !== 1'b0 || InstrValidF !== 1'b0 || FetchWaitF !== 1'b1) begin
        bad++; $display("FAIL drop_cycle%0d got req=%b val=%b wait=%b exp=0/0/1",
                        i, imem_req, InstrValidF, FetchWaitF);
      end
      total++;
      if (PCF !== 32'h0000_0200) begin
        bad++; $display("FAIL drop_pc got=%h exp=200", PCF);
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || InstrValidF !== 1'b1) begin
      bad++; $display("FAIL drop_refetch got req=%b addr=%h val=%b exp=1/200/1",
                      imem_req, imem_addr, InstrValidF);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      total++;
      if (PCF !== 32'h8 || imem_addr !== 32'h8 || InstrValidF !== 1'b1) begin
        bad++; $display("FAIL stall_hold got pc=%h addr=%h val=%b exp=8/8/1",
                        PCF, imem_addr, InstrValidF);
      end
      tick();
    end
    drive(1'b0, 1'b1, 32'h0000_0042, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (PCF !== 32'h0000_0040) begin
      bad++; $display("FAIL stall_redirect got=%h exp=40", PCF);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
      bad++; $display("FAIL wrap_plus4 got pc=%h p4=%h exp=fffffffc/0", PCF, PCPlus4F);
    end
    tick();
    total++;
    if (PCF !== 32'h0) begin
      bad++; $display("FAIL wrap_pc got=%h exp=0", PCF);
    end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL rstdrop_req got=%b exp=0", imem_req);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (PCF !== 32'h0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL rstdrop_fetch got pc=%h req=%b exp=0/1", PCF, imem_req);
    end
  endtask

  // Reference: track the PC and how many stale responses are still owed.
  task automatic test_random();
    logic [31:0] m_pc;
    int          owed;
    logic        r, ps, st, rdy;
    logic [31:0] t;
    logic        e_req, e_val, e_fl;
    do_reset();
    m_pc = 32'h0;
    owed = 0;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(39) == 0);
      ps  = ($urandom_range(4) == 0);
      st  = ($urandom_range(3) == 0);
      rdy = $urandom_range(1);
      t   = $urandom;
      drive(r, ps, t, st, rdy);
      e_req = !r && owed == 0;
      e_val = e_req && rdy && !ps;
      e_fl  = !r && ps;
      total++;
      if (imem_req !== e_req || InstrValidF !== e_val || FetchWaitF !== !e_val) begin
        bad++; $display("FAIL rnd_ctl n=%0d got %b%b%b exp %b%b%b", n,
                        imem_req, InstrValidF, FetchWaitF, e_req, e_val, !e_val);
      end
      total++;
      if (FlushD !== e_fl || FlushE !== e_fl) begin
        bad++; $display("FAIL rnd_flush n=%0d got %b%b exp %b", n, FlushD, FlushE, e_fl);
      end
      total++;
      if (PCF !== m_pc || imem_addr !== m_pc || PCPlus4F !== m_pc + 32'd4) begin
        bad++; $display("FAIL rnd_pc n=%0d got %h/%h/%h exp %h", n,
                        PCF, imem_addr, PCPlus4F, m_pc);
      end
      if (r) begin
        m_pc = 32'h0;
        owed = 0;
      end else begin
        if (ps) m_pc = {t[31:2], 2'b00};
        else if (owed == 0 && rdy && !st) m_pc = m_pc + 32'd4;
        if (owed == 0) owed = (ps && !rdy) ? 1 : 0;
        else if (rdy) owed = 0;
      end
      tick();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_sequential();
    test_redirect();
    test_drop();
    test_stall();
    test_wrap();
    test_reset_in_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect.md
# pc_redirect

Fetch-stage PC generator and redirect controller for the pipelined RV32I core. Consumes the execute-stage branch/jump decision (`PCSrcE`, `PCTargetE`), which is the receiving end of branch resolution. Owns the fetch PC register, drives a request/ready handshake to instruction memory, and discards stale instruction responses after a redirect. Raises the decode and execute flushes that squash wrong-path instructions.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset

Ports:
- `clk`  in  1  core clock, rising edge
- `reset`  in  1  synchronous, active-high
- `PCSrcE`  in  1  execute-stage redirect request (taken branch, jal, jalr)
- `PCTargetE`  in  XLEN  redirect target from execute
- `StallF`  in  1  hazard-unit fetch stall
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  XLEN  fetch address
- `imem_ready`  in  1  instruction memory response valid this cycle, for the oldest outstanding request
- `InstrValidF`  out  1  fetched instruction is valid and on the correct path
- `FetchWaitF`  out  1  fetch has no valid instruction this cycle; decode inserts a bubble
- `PCF`  out  XLEN  current fetch PC
- `PCPlus4F`  out  XLEN  `PCF` + 4, modulo 2^XLEN
- `FlushD`  out  1  squash the IF/ID register
- `FlushE`  out  1  squash the ID/EX register

## Operation
- Reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: `PCF` = `RESET_PC`, state = FETCH, `imem_req` = 0, `InstrValidF` = 0, `FlushD` = `FlushE` = 0.
- State FETCH:
  - `imem_req` = 1 and `imem_addr` = `PCF`, except while `reset` is high.
  - `imem_ready` & ~`PCSrcE` & ~`StallF`: `InstrValidF` = 1, `PCF` <= `PCF` + 4.
  - `imem_ready` & ~`PCSrcE` & `StallF`: `InstrValidF` = 1, `PCF` holds. The same address is fetched again next cycle (refetch policy, no internal buffer).
  - ~`imem_ready` & ~`PCSrcE`: `InstrValidF` = 0, `FetchWaitF` = 1, `PCF` holds.
  - `PCSrcE` & `imem_ready`: response discarded (`InstrValidF` = 0). `PCF` <= target. Stay in FETCH.
  - `PCSrcE` & ~`imem_ready`: `PCF` <= target. Go to DROP, because the outstanding response is now stale.
- State DROP:
  - `imem_req` = 0, `InstrValidF` = 0, `FetchWaitF` = 1.
  - On `imem_ready`: discard the response and go to FETCH.
  - `PCSrcE` in DROP: `PCF` <= new target. Stay in DROP (still one stale response owed).
- Target loading: `PCF` <= {`PCTargetE`[XLEN-1:2], 2'b00}. Bits [1:0] are forced to zero.
- `PCSrcE` has priority over `StallF`. A redirect is never delayed by a fetch stall.
- `FlushD` = `FlushE` = `PCSrcE` (combinational), in both states. The hazard unit ORs in its own load-use `FlushE`.
- `FetchWaitF` = ~`InstrValidF`.

## Timing
- `PCF` and state are registered. `imem_req`, `imem_addr`, `InstrValidF`, `FetchWaitF`, `FlushD` and `FlushE` are combinational from state, `PCF` and current inputs.
- Redirect latency: `PCSrcE` high in cycle N gives `PCF` = target in N+1. That target is requested in N+1 from FETCH, or in the cycle after the stale `imem_ready` from DROP.
- Zero-wait memory (`imem_ready` always high): one instruction per cycle; a taken branch costs 2 bubbles (IF/ID and ID/EX flushed).
- At most one request is outstanding. `imem_addr` is stable while `imem_req` is high and `imem_ready` is low, unless `PCSrcE` arrives.
- `reset` in DROP: return to FETCH with `RESET_PC`. The memory is reset on the same `reset`, so no stale response survives.
- `PCPlus4F` wraps: `PCF` = 32'hFFFF_FFFC gives `PCPlus4F` = 0.

## Structure
- Shared package `pipeline_pkg`:
  - opcode constants `OP_BRANCH` (7'b1100011), `OP_JAL` (7'b1101111), `OP_JALR` (7'b1100111)
  - `fetch_state_t` enum {FETCH, DROP}
  - `RESET_PC_DEFAULT`
- One sub-module, `pc_reg`: XLEN-bit flop with synchronous reset to a parameter value and a load enable. The FSM and next-PC mux stay in `pc_redirect`.

## Test plan
- Reset then `imem_ready` = 1 for 4 cycles, no stall: `PCF` sequence 0, 4, 8, 12; `InstrValidF` = 1 every cycle after reset.
- `PCSrcE` = 1, `PCTargetE` = 32'h0000_0103, with `imem_ready` = 1: `FlushD` = `FlushE` = 1 that cycle, `InstrValidF` = 0, next `PCF` = 32'h0000_0100.
- `PCSrcE` with `imem_ready` = 0, memory responds 3 cycles later: state DROP, `imem_req` = 0 for those cycles, stale response not valid, next cycle requests the target address.
- `StallF` = 1 for 2 cycles at `PCF` = 8, `imem_ready` = 1: `PCF` holds at 8, `imem_addr` = 8 repeated. `StallF` together with `PCSrcE` still loads the target.
- `PCF` = 32'hFFFF_FFFC, advance: `PCPlus4F` = 0 and next `PCF` = 0. Assert `reset` mid-DROP: next `PCF` = `RESET_PC`, state FETCH, `imem_req` = 0 while reset is high.
